// File: rtl/button_scan_scheduler.sv
// -----------------------------------------------------------------------------
// button_scan_scheduler
//
// Round-robin debouncer for a small bank of push-buttons. A single shared
// counter is lent to one button at a time: the scan pointer walks the buttons
// until one whose synchronized level differs from its debounced level is
// found. The scheduler then parks on that button. The new level is accepted
// only after it has stayed stable for DEB_COUNT consecutive cycles. An
// accepted press (0 -> 1) produces a one-cycle strobe. An accepted release
// only clears the debounced level.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-low reset
//   btn_raw    : raw asynchronous button pins, active-high (N_BTN bits)
//   enable     : scanning enable; low aborts any qualification and freezes
//                the scan pointer
//   pulse      : one-cycle press strobe per button, at most one bit set
//   held       : debounced level per button
//   busy       : high while a button is being qualified
//   active_idx : current scan pointer
// -----------------------------------------------------------------------------
module button_scan_scheduler #(
    parameter int N_BTN     = 4,
    parameter int DEB_COUNT = 5000000,
    parameter int CNT_W     = 23,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             enable,
    output logic [N_BTN-1:0] pulse,
    output logic [N_BTN-1:0] held,
    output logic             busy,
    output logic [IDX_W-1:0] active_idx
);

    typedef enum logic [0:0] {
        ST_SCAN    = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BTN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_COUNT - 1);

    logic [N_BTN-1:0] sync1_r;
    logic [N_BTN-1:0] sync2_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             target_r;
    logic [IDX_W-1:0] ptr_r;
    logic [N_BTN-1:0] held_r;
    logic [N_BTN-1:0] pulse_r;
    logic             busy_r;

    logic [IDX_W-1:0] ptr_next_s;
    logic             sync_bit_s;
    logic             held_bit_s;

    // Two-flop synchronizer per button; nothing downstream looks at btn_raw.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= {N_BTN{1'b0}};
            sync2_r <= {N_BTN{1'b0}};
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Wrap-around successor of the scan pointer and the bits it selects.
    always_comb begin
        ptr_next_s = {IDX_W{1'b0}};
        sync_bit_s = sync2_r[ptr_r];
        held_bit_s = held_r[ptr_r];
        if (ptr_r == LAST_IDX) begin
            ptr_next_s = {IDX_W{1'b0}};
        end else begin
            ptr_next_s = ptr_r + IDX_W'(1);
        end
    end

    // Scan/qualify state machine with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_SCAN;
            cnt_r    <= {CNT_W{1'b0}};
            target_r <= 1'b0;
            ptr_r    <= {IDX_W{1'b0}};
            held_r   <= {N_BTN{1'b0}};
            pulse_r  <= {N_BTN{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            // Strobe lasts a single cycle unless re-asserted below.
            pulse_r <= {N_BTN{1'b0}};
            if (!enable) begin
                // Pointer stays put so scanning resumes on the same button.
                state_r <= ST_SCAN;
                cnt_r   <= {CNT_W{1'b0}};
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_SCAN: begin
                        if (sync_bit_s != held_bit_s) begin
                            target_r <= sync_bit_s;
                            cnt_r    <= {CNT_W{1'b0}};
                            state_r  <= ST_QUALIFY;
                            busy_r   <= 1'b1;
                        end else begin
                            ptr_r <= ptr_next_s;
                        end
                    end
                    ST_QUALIFY: begin
                        if (sync_bit_s != target_r) begin
                            // Level bounced back: give the counter to the next button.
                            cnt_r   <= {CNT_W{1'b0}};
                            ptr_r   <= ptr_next_s;
                            state_r <= ST_SCAN;
                            busy_r  <= 1'b0;
                        end else if (cnt_r != CNT_LAST) begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end else begin
                            // Stable long enough; only a press is strobed.
                            held_r[ptr_r]  <= target_r;
                            pulse_r[ptr_r] <= target_r;
                            cnt_r          <= {CNT_W{1'b0}};
                            ptr_r          <= ptr_next_s;
                            state_r        <= ST_SCAN;
                            busy_r         <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_SCAN;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pulse      = pulse_r;
    assign held       = held_r;
    assign busy       = busy_r;
    assign active_idx = ptr_r;

endmodule

// File: tb/tb_button_scan_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for button_scan_scheduler with N_BTN=4, DEB_COUNT=4.
// A behavioural model tracks the debouncer in terms of "which button is being
// watched and how many stable cycles it still needs". Every negative clock
// edge the DUT outputs are compared against that model. Directed scenarios add
// hand-computed literal expectations (exact pulse cycles, ordering, counts).
// -----------------------------------------------------------------------------
module tb_button_scan_scheduler;

    localparam int N   = 4;
    localparam int DEB = 4;

    logic         clk     = 1'b0;
    logic         rst     = 1'b0;
    logic         enable  = 1'b0;
    logic [N-1:0] btn_raw = 4'b0000;
    logic [N-1:0] pulse;
    logic [N-1:0] held;
    logic         busy;
    logic [1:0]   active_idx;

    int checks   = 0;
    int failures = 0;

    button_scan_scheduler #(
        .N_BTN    (N),
        .DEB_COUNT(DEB),
        .CNT_W    (3),
        .IDX_W    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .enable    (enable),
        .pulse     (pulse),
        .held      (held),
        .busy      (busy),
        .active_idx(active_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs seen at each rising edge.
    logic [N-1:0] smp_btn = 4'b0000;
    logic         smp_en  = 1'b0;
    logic         smp_rst = 1'b0;

    always @(posedge clk) begin
        smp_btn <= btn_raw;
        smp_en  <= enable;
        smp_rst <= rst;
    end

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_h1    = 4'b0000;   // btn one edge ago
    logic [N-1:0] m_h2    = 4'b0000;   // btn two edges ago (what decisions see)
    logic [N-1:0] m_held  = 4'b0000;
    logic [N-1:0] m_pulse = 4'b0000;
    int           m_ptr   = 0;
    bit           m_watch = 1'b0;      // a button is being qualified
    logic         m_tgt   = 1'b0;
    int           m_left  = 0;         // stable cycles still needed

    task automatic model_reset();
        m_h1 = 4'b0000; m_h2 = 4'b0000; m_held = 4'b0000; m_pulse = 4'b0000;
        m_ptr = 0; m_watch = 1'b0; m_tgt = 1'b0; m_left = 0;
    endtask

    task automatic model_step(input logic [N-1:0] b, input logic e);
        logic [N-1:0] seen;
        seen    = m_h2;
        m_pulse = 4'b0000;
        if (!e) begin
            m_watch = 1'b0;
        end else if (!m_watch) begin
            if (seen[m_ptr] !== m_held[m_ptr]) begin
                m_watch = 1'b1;
                m_tgt   = seen[m_ptr];
                m_left  = DEB;
            end else begin
                m_ptr = (m_ptr + 1) % N;
            end
        end else if (seen[m_ptr] !== m_tgt) begin
            m_watch = 1'b0;
            m_ptr   = (m_ptr + 1) % N;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_held[m_ptr]  = m_tgt;
                m_pulse[m_ptr] = m_tgt;
                m_watch        = 1'b0;
                m_ptr          = (m_ptr + 1) % N;
            end
        end
        m_h2 = m_h1;
        m_h1 = b;
    endtask

    // Compare process: advance model, then check every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst || !smp_rst) model_reset();
            else model_step(smp_btn, smp_en);
            chk("model_pulse", pulse, m_pulse);
            chk("model_held", held, m_held);
            chk("model_busy", busy, m_watch);
            chk("model_idx", active_idx, m_ptr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Returns at the start of the first cycle out of reset (pointer = 0).
    task automatic do_reset(input logic en);
        next_cycle();
        btn_raw = 4'b0000;
        enable  = en;
        #1 rst = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b1;
    endtask

    int w_cnt [N];
    int w_first [N];
    int w_both;
    int w_abort;

    task automatic run_window(input int n);
        logic prev_busy;
        prev_busy = 1'b0;
        for (int i = 0; i < N; i++) begin w_cnt[i] = 0; w_first[i] = -1; end
        w_both = 0; w_abort = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (pulse[i]) begin
                    w_cnt[i]++;
                    if (w_first[i] < 0) w_first[i] = k;
                end
            end
            if ($countones(pulse) > 1) w_both++;
            if (prev_busy && !busy && pulse == 4'b0000) w_abort++;
            prev_busy = busy;
            next_cycle();
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        // Reset state before any clock edge.
        #3;
        chk("rst_pulse", pulse, 4'b0000);
        chk("rst_held", held, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_idx", active_idx, 2'd0);

        // Clean press of button 0, pointer parked on 0 until the sync output is ready.
        do_reset(1'b0);
        btn_raw = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) enable = 1'b1;
            @(negedge clk);
            chk("clean_busy", busy, (k >= 3 && k <= 6));
            chk("clean_pulse", pulse, (k == 7) ? 4'b0001 : 4'b0000);
            chk("clean_held0", held[0], (k >= 7));
            next_cycle();
        end

        // Bounce on button 2: first capture aborts, second qualifies.
        do_reset(1'b1);
        repeat (4) next_cycle();
        w_abort = 0;
        begin
            logic pb;
            pb = 1'b0;
            for (int k = 0; k < 20; k++) begin
                btn_raw[2] = (k < 2 || k >= 4) ? 1'b1 : 1'b0;
                @(negedge clk);
                chk("bounce_pulse", pulse, (k == 13) ? 4'b0100 : 4'b0000);
                if (pb && !busy && pulse == 4'b0000) w_abort++;
                pb = busy;
                next_cycle();
            end
        end
        chk("bounce_abort_seen", (w_abort > 0), 1'b1);
        chk("bounce_held", held, 4'b0100);

        // Long hold then release of button 1, then a second press.
        do_reset(1'b1);
        btn_raw = 4'b0010;
        run_window(100);
        chk("hold_pulse1", w_cnt[1], 1);
        chk("hold_other", w_cnt[0] + w_cnt[2] + w_cnt[3], 0);
        chk("hold_held", held, 4'b0010);
        btn_raw = 4'b0000;
        begin
            int np;
            np = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                np += $countones(pulse);
                if (k == 6) chk("release_still_held", held[1], 1'b1);
                if (k == 11) chk("release_cleared", held, 4'b0000);
                next_cycle();
            end
            chk("release_no_pulse", np, 0);
        end
        btn_raw = 4'b0010;
        run_window(20);
        chk("repress_pulse1", w_cnt[1], 1);
        chk("repress_held", held, 4'b0010);

        // Simultaneous presses on buttons 1 and 3.
        do_reset(1'b1);
        repeat (2) next_cycle();
        btn_raw = 4'b1010;
        run_window(30);
        chk("simul_cnt1", w_cnt[1], 1);
        chk("simul_cnt3", w_cnt[3], 1);
        chk("simul_both", w_both, 0);
        chk("simul_first1", w_first[1], 8);
        chk("simul_first3", w_first[3], 14);
        chk("simul_gap", (w_first[3] - w_first[1] >= 5), 1'b1);

        // enable dropped mid-qualification of button 0.
        do_reset(1'b0);
        btn_raw = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            if (k == 2) enable = 1'b1;
            if (k == 4) enable = 1'b0;
            if (k == 8) enable = 1'b1;
            @(negedge clk);
            if (k == 4) chk("en_busy_before", busy, 1'b1);
            if (k == 5) chk("en_busy_drop", busy, 1'b0);
            chk("en_pulse", pulse, (k == 13) ? 4'b0001 : 4'b0000);
            chk("en_held0", held[0], (k >= 13));
            next_cycle();
        end

        // Asynchronous reset during qualification.
        do_reset(1'b0);
        btn_raw = 4'b0001;
        repeat (2) next_cycle();
        enable = 1'b1;
        repeat (2) next_cycle();
        chk("arst_busy_before", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_all", {pulse, held, active_idx}, 10'd0);
        next_cycle();
        rst = 1'b1;
        run_window(20);
        chk("arst_requal_pulse", w_cnt[0], 1);
        chk("arst_requal_other", w_cnt[1] + w_cnt[2] + w_cnt[3], 0);
        chk("arst_requal_held", held, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
